// File: rtl/edp_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : edp_mul_seq
// Brief    : Sequencer for an iterative add/shift multiply with optional
//            final subtract correction.
// Revision : 1.0
// ============================================================================
module edp_mul_seq #(
    parameter int MAX_STEPS = 36
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] steps,
    input  logic       sign_fix,
    input  logic       mq35,
    output logic       busy,
    output logic       done,
    output logic [1:0] ad_op,
    output logic [1:0] mq_sel,
    output logic       ar_clr,
    output logic       ar_load,
    output logic       arx_load,
    output logic [5:0] count
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_STEP  = 3'd2;
    localparam logic [2:0] c_FIXUP = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [5:0] c_MAX_STEPS = 6'(MAX_STEPS);

    localparam logic [1:0] c_AD_PASS = 2'b00;
    localparam logic [1:0] c_AD_ADD  = 2'b01;
    localparam logic [1:0] c_AD_SUB  = 2'b10;

    localparam logic [1:0] c_MQ_HOLD = 2'b00;
    localparam logic [1:0] c_MQ_SHR  = 2'b01;
    localparam logic [1:0] c_MQ_LOAD = 2'b11;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [5:0] r_count;
    logic       r_fix;
    logic [5:0] w_clamped;

    assign w_clamped = (steps > c_MAX_STEPS) ? c_MAX_STEPS : steps;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (start) w_next = c_LOAD;
                c_LOAD: begin
                    if (r_count != 6'd0) w_next = c_STEP;
                    else                 w_next = r_fix ? c_FIXUP : c_DONE;
                end
                c_STEP:  if (r_count == 6'd1) w_next = r_fix ? c_FIXUP : c_DONE;
                c_FIXUP: w_next = c_DONE;
                c_DONE:  w_next = c_IDLE;
                default: w_next = c_IDLE;
            endcase
        end
    end

    // Iteration count and fix flag are only captured on an accepted start,
    // so a start arriving mid-sequence cannot disturb them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 6'd0;
            r_fix   <= 1'b0;
        end else if (abort) begin
            r_count <= 6'd0;
        end else if (r_state == c_IDLE && start) begin
            r_count <= w_clamped;
            r_fix   <= sign_fix;
        end else if (r_state == c_STEP && r_count != 6'd0) begin
            r_count <= r_count - 6'd1;
        end
    end

    always_comb begin
        busy     = (r_state != c_IDLE);
        done     = 1'b0;
        ad_op    = c_AD_PASS;
        mq_sel   = c_MQ_HOLD;
        ar_clr   = 1'b0;
        ar_load  = 1'b0;
        arx_load = 1'b0;
        count    = r_count;
        case (r_state)
            c_LOAD: begin
                mq_sel  = c_MQ_LOAD;
                ar_clr  = 1'b1;
                ar_load = 1'b1;
            end
            c_STEP: begin
                ad_op    = mq35 ? c_AD_ADD : c_AD_PASS;
                mq_sel   = c_MQ_SHR;
                ar_load  = 1'b1;
                arx_load = 1'b1;
            end
            c_FIXUP: begin
                ad_op   = c_AD_SUB;
                ar_load = 1'b1;
            end
            c_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/edp_mul_seq.md
EDP_MUL_SEQ -- requirements
Module: edp_mul_seq

Interface
REQ-001 Parameter: MAX_STEPS, default 36, upper bound on iteration count; larger requests are clamped to it.
REQ-002 Port: clk, input, 1, EDP clock; all state changes on its rising edge.
REQ-003 Port: reset, input, 1; synchronous, active-high.
REQ-004 Port: start, input, 1; request a multiply sequence, sampled only in IDLE.
REQ-005 Port: abort, input, 1; cancel the sequence from any state.
REQ-006 Port: steps, input, 6; iteration count, captured on an accepted start.
REQ-007 Port: sign_fix, input, 1; request a final subtract correction, captured on an accepted start.
REQ-008 Port: mq35, input, 1; current MQ bit 35, selects add or pass for each step.
REQ-009 Port: busy, output, 1; high whenever state is not IDLE.
REQ-010 Port: done, output, 1; single-cycle completion pulse.
REQ-011 Port: ad_op, output, 2; AD control: 00 pass (A), 01 A+B, 10 A-B, 11 unused.
REQ-012 Port: mq_sel, output, 2; USR4 select: 00 hold, 01 shift right, 10 shift left (unused), 11 load.
REQ-013 Port: ar_clr, output, 1; clear the ARM input.
REQ-014 Port: ar_load, output, 1; load AR.
REQ-015 Port: arx_load, output, 1; load ARX.
REQ-016 Port: count, output, 6; remaining iterations.

Function
REQ-017 States are IDLE, LOAD, STEP, FIXUP and DONE, encoded in a single state register.
REQ-018 In IDLE, all control outputs are 0, mq_sel=00, and done=0.
REQ-019 In IDLE, start=1 with abort=0 moves to LOAD and captures:
- count = min(steps, MAX_STEPS);
- the fix flag = sign_fix.
REQ-020 LOAD lasts one cycle and drives mq_sel=11, ar_clr=1, ar_load=1, ad_op=00.
REQ-021 LOAD goes to STEP if count != 0.
REQ-022 LOAD goes to FIXUP if count == 0 and the fix flag is set.
REQ-023 LOAD goes to DONE if count == 0 and the fix flag is clear.
REQ-024 Each STEP cycle drives:
- ad_op = 01 if mq35 = 1, else 00;
- ar_load = 1, arx_load = 1, mq_sel = 01;
- count decrements by 1.
REQ-025 STEP exits when count == 1 at the clock edge: to FIXUP if the fix flag is set, otherwise to DONE; count reaches 0 on that edge.
REQ-026 FIXUP lasts one cycle and drives ad_op=10, ar_load=1, arx_load=0, mq_sel=00.
REQ-027 FIXUP then goes to DONE.
REQ-028 DONE lasts one cycle with done=1 and all loads 0, then goes to IDLE.
REQ-029 Latency from the start edge to the done pulse is 2 + N + F cycles (N = clamped steps, F = fix flag).
REQ-030 abort=1 in any state forces IDLE on the next edge.
- Outputs are driven as in IDLE from that edge onward.
- No done pulse is produced, and count is cleared to 0.
REQ-031 If abort and start are both high in IDLE, abort wins and the block stays in IDLE.
REQ-032 A start seen while busy is ignored; it is neither queued nor allowed to alter the captured steps or fix flag.
REQ-033 count never wraps below 0; a decrement at 0 is impossible by construction and shall not occur.
REQ-034 All outputs are registered state decodes or combinational from state and mq35 only; they have no combinational path from start or abort.

Reset
REQ-035 While reset=1 at a rising edge: state becomes IDLE, count=0, the fix flag is 0, and busy=0, done=0.
REQ-036 Reset overrides start and abort, including in the middle of a sequence.
REQ-037 The first cycle after reset deasserts accepts a start.

Verification
REQ-038 Basic multiply: start, steps=4, sign_fix=0, mq35 pattern 1,0,1,1.
- Expect ad_op 01,00,01,01 over STEP.
- Expect done exactly 6 cycles after the start edge, count=0, busy low after done.
REQ-039 Fixup path: steps=36, sign_fix=1.
- Expect 36 STEP cycles, then one FIXUP cycle with ad_op=10, arx_load=0.
- Expect done at cycle 39.
REQ-040 Boundaries:
- steps=0, sign_fix=0: LOAD then DONE, done at cycle 2, no STEP cycles.
- steps=63 with MAX_STEPS=36: exactly 36 STEP cycles.
REQ-041 Abort: abort asserted on the 3rd STEP cycle.
- Expect IDLE next edge, count=0, no done.
- A start together with abort in IDLE stays in IDLE.
REQ-042 Reset and start while busy:
- reset mid-STEP gives IDLE and count=0 on the next edge.
- A start pulsed during STEP leaves the sequence length and done timing unchanged.
